// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path.
//   - parity encodings (PAR_EVEN/PAR_ODD), same encoding as the transmitter
//   - line levels of the start and stop bits
//   - receiver FSM state encoding
//   - 2-of-3 majority helper used by the bit sampler
package uart_rx_pkg;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-period timing and majority vote for the UART receiver.
//   clk, rst     : oversampling clock, async active-high reset
//   rxs          : synchronized serial line
//   cnt_clr      : hold the edge counter at 0 (receiver idle / frame ending)
//   sample_done  : high in the cycle of the third sample; bit_val is valid then
//   bit_end      : last cycle of the current bit period
//   bit_val      : 2-of-3 majority of the samples at OVERSAMPLE/2-1, /2, /2+1
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic rxs,
  input  logic cnt_clr,
  output logic sample_done,
  output logic bit_end,
  output logic bit_val
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] SMP_A = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] SMP_B = CW'(OVERSAMPLE/2);
  localparam logic [CW-1:0] SMP_C = CW'(OVERSAMPLE/2 + 1);
  localparam logic [CW-1:0] LAST  = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] edge_cnt;
  logic [1:0]    smp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      smp      <= 2'b11;
    end else begin
      if (cnt_clr)               edge_cnt <= '0;
      else if (edge_cnt == LAST) edge_cnt <= '0;
      else                       edge_cnt <= edge_cnt + CW'(1);
      if (edge_cnt == SMP_A) smp[0] <= rxs;
      if (edge_cnt == SMP_B) smp[1] <= rxs;
    end
  end

  // The third sample is taken straight off the line so the vote is available
  // in the sampling cycle; the consumer registers it, so the decision is
  // visible from the following cycle.
  assign sample_done = (edge_cnt == SMP_C);
  assign bit_end     = (edge_cnt == LAST);
  assign bit_val     = maj3(smp[0], smp[1], rxs);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled, majority-voted, optional parity, one stop bit.
//   clk, rst     : oversampling clock (OVERSAMPLE cycles per bit), async active-high reset
//   rx_in        : raw serial line, idle high, asynchronous to clk
//   parity_en    : frame carries a parity bit (latched while idle)
//   parity_type  : 0 even, 1 odd (latched while idle)
//   p_data       : last good received word
//   data_valid   : one-cycle strobe, p_data updated in the same cycle
//   parity_err   : one-cycle strobe, parity mismatch
//   stop_err     : one-cycle strobe, stop bit sampled low
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DWIDTH     = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  input  logic              parity_en,
  input  logic              parity_type,
  output logic [DWIDTH-1:0] p_data,
  output logic              data_valid,
  output logic              parity_err,
  output logic              stop_err
);

  localparam int BW = $clog2(DWIDTH + 1);

  logic [1:0]        sync_q;
  logic              rxs;
  rx_state_e         state, state_nx;
  logic              sample_done, bit_end, bit_val, cnt_clr, start_go;
  logic [DWIDTH-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic              par_en_q, par_type_q, par_bad_q, brk_q;

  assign rxs = sync_q[1];

  // After a break the line must return high before a new start is accepted.
  assign start_go = (state == RX_IDLE) && (rxs == START_BIT) && !brk_q;

  // Clearing on the transition into IDLE (not only while in IDLE) keeps the
  // counter at 0 for a start edge arriving in the very next cycle.
  assign cnt_clr = (state_nx == RX_IDLE);

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .rxs        (rxs),
    .cnt_clr    (cnt_clr),
    .sample_done(sample_done),
    .bit_end    (bit_end),
    .bit_val    (bit_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RX_IDLE:   if (start_go) state_nx = RX_START;
      RX_START: begin
        if (sample_done && bit_val != START_BIT) state_nx = RX_IDLE;  // glitch
        else if (bit_end)                        state_nx = RX_DATA;
      end
      RX_DATA:   if (bit_end && bit_cnt == BW'(DWIDTH))
                   state_nx = par_en_q ? RX_PARITY : RX_STOP;
      RX_PARITY: if (bit_end) state_nx = RX_STOP;
      // Leave mid stop bit so a back-to-back start edge is not missed.
      RX_STOP:   if (sample_done) state_nx = RX_IDLE;
      default:   state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= 2'b11;
      p_data     <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      stop_err   <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      par_bad_q  <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx_in};
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      stop_err   <= 1'b0;
      case (state)
        RX_IDLE: begin
          par_en_q   <= parity_en;
          par_type_q <= parity_type;
          bit_cnt    <= '0;
          par_bad_q  <= 1'b0;
          if (brk_q && rxs == STOP_BIT) brk_q <= 1'b0;
        end
        RX_DATA: if (sample_done) begin
          shreg   <= DWIDTH'({bit_val, shreg} >> 1);  // LSB arrives first
          bit_cnt <= bit_cnt + BW'(1);
        end
        RX_PARITY: if (sample_done)
          par_bad_q <= bit_val != (^shreg ^ (par_type_q == PAR_ODD));
        RX_STOP: if (sample_done) begin
          if (bit_val == STOP_BIT && !par_bad_q) begin
            data_valid <= 1'b1;
            p_data     <= shreg;
          end
          if (bit_val != STOP_BIT) begin
            stop_err <= 1'b1;
            brk_q    <= 1'b1;
          end
          if (par_bad_q) parity_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
